// File: rtl/ee354_gcd_pkg.sv
// Shared definitions for the ee354 GCD core: one-hot state encoding and default width.
// State bit order matches the {q_I, q_Sub, q_Mult, q_Done} output bundle.
package ee354_gcd_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [3:0] QI    = 4'b1000;
  localparam logic [3:0] QSUB  = 4'b0100;
  localparam logic [3:0] QMULT = 4'b0010;
  localparam logic [3:0] QDONE = 4'b0001;

  typedef enum logic [3:0] {
    S_I    = QI,
    S_SUB  = QSUB,
    S_MULT = QMULT,
    S_DONE = QDONE
  } state_t;

endpackage

// File: rtl/ee354_sat_counter.sv
// Saturating up-counter with synchronous reset, clock enable and synchronous clear.
// Clear wins over increment; the count sticks at all-ones instead of wrapping.
module ee354_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      if (clr)
        q <= '0;
      else if (inc && (q != {W{1'b1}}))
        q <= q + W'(1);
    end
  end

endmodule

// File: rtl/ee354_gcd_param.sv
// Parametrised GCD core: binary subtract/halve reduction, then a doubling phase that
// restores the common powers of two. Zero operands short-cut straight to the result.
module ee354_gcd_param
  import ee354_gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1,
  parameter int CYC_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CEN,
  input  logic             Start,
  input  logic             Ack,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] AB_GCD,
  output logic [CNT_W-1:0] i_count,
  output logic [CYC_W-1:0] Cycles,
  output logic             q_I,
  output logic             q_Sub,
  output logic             q_Mult,
  output logic             q_Done
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_nx, b_nx, gcd_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             cyc_clr, cyc_inc;

  assign {q_I, q_Sub, q_Mult, q_Done} = state;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_I;
      A       <= '0;
      B       <= '0;
      AB_GCD  <= '0;
      i_count <= '0;
    end else if (CEN) begin
      state   <= state_nx;
      A       <= a_nx;
      B       <= b_nx;
      AB_GCD  <= gcd_nx;
      i_count <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = A;
    b_nx     = B;
    gcd_nx   = AB_GCD;
    cnt_nx   = i_count;
    cyc_clr  = 1'b0;
    cyc_inc  = 1'b0;
    case (state)
      S_I: begin
        a_nx   = Ain;
        b_nx   = Bin;
        cnt_nx = '0;
        if (Start) begin
          cyc_clr = 1'b1;
          // GCD(x,0)=x and GCD(0,0)=0, so OR-ing the operands is the whole answer.
          if ((Ain == '0) || (Bin == '0)) begin
            state_nx = S_DONE;
            gcd_nx   = Ain | Bin;
          end else begin
            state_nx = S_SUB;
          end
        end
      end
      S_SUB: begin
        cyc_inc = 1'b1;
        if (A == B) begin
          state_nx = S_MULT;
        end else if (!A[0] && !B[0]) begin
          a_nx   = A >> 1;
          b_nx   = B >> 1;
          cnt_nx = i_count + CNT_W'(1);
        end else if (!A[0]) begin
          a_nx = A >> 1;
        end else if (!B[0]) begin
          b_nx = B >> 1;
        end else if (A > B) begin
          a_nx = A - B;
        end else begin
          b_nx = B - A;
        end
      end
      S_MULT: begin
        cyc_inc = 1'b1;
        if (i_count == '0) begin
          state_nx = S_DONE;
          gcd_nx   = A;
        end else begin
          a_nx   = A << 1;
          cnt_nx = i_count - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (Ack)
          state_nx = S_I;
      end
      default: state_nx = S_I;
    endcase
  end

  ee354_sat_counter #(
    .W(CYC_W)
  ) u_cycles (
    .clk  (Clk),
    .reset(Reset),
    .en   (CEN),
    .clr  (cyc_clr),
    .inc  (cyc_inc),
    .q    (Cycles)
  );

endmodule

// File: tb/tb_ee354_gcd_param.sv
// Bench for ee354_gcd_param: three instances (8-bit, 16-bit, 8-bit with a 3-bit cycle
// counter) share stimulus and are compared against a behavioural GCD/cycle model.
module tb_ee354_gcd_param;

  logic        Clk = 1'b0;
  logic        Reset, CEN, Start, Ack;
  logic [15:0] Ain, Bin;
  logic [7:0]  ain8, bin8;
  assign ain8 = Ain[7:0];
  assign bin8 = Bin[7:0];

  logic [7:0]  a8, b8, g8;
  logic [3:0]  ic8;
  logic [15:0] cy8;
  logic        qi8, qs8, qm8, qd8;

  logic [15:0] a16, b16, g16;
  logic [4:0]  ic16;
  logic [15:0] cy16;
  logic        qi16, qs16, qm16, qd16;

  logic [7:0]  as, bs, gs;
  logic [3:0]  ics;
  logic [2:0]  cys;
  logic        qis, qss, qms, qds;

  always #5 Clk = ~Clk;

  ee354_gcd_param #(.WIDTH(8), .CYC_W(16)) dut8 (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
    .Ain(ain8), .Bin(bin8), .A(a8), .B(b8), .AB_GCD(g8), .i_count(ic8),
    .Cycles(cy8), .q_I(qi8), .q_Sub(qs8), .q_Mult(qm8), .q_Done(qd8));

  ee354_gcd_param #(.WIDTH(16), .CYC_W(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
    .Ain(Ain), .Bin(Bin), .A(a16), .B(b16), .AB_GCD(g16), .i_count(ic16),
    .Cycles(cy16), .q_I(qi16), .q_Sub(qs16), .q_Mult(qm16), .q_Done(qd16));

  ee354_gcd_param #(.WIDTH(8), .CYC_W(3)) duts (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
    .Ain(ain8), .Bin(bin8), .A(as), .B(bs), .AB_GCD(gs), .i_count(ics),
    .Cycles(cys), .q_I(qis), .q_Sub(qss), .q_Mult(qms), .q_Done(qds));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int exp_g[3], exp_c[3], prev_g[3], prev_c[3], obs[3], lat[3];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference: Euclid for the value, spec reduction rules for the clock count.
  function automatic int model_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int model_cycles(input int x, input int y);
    int n, k;
    n = 0;
    k = 0;
    if (x == 0 || y == 0) return 0;
    while (x != y) begin
      n++;
      if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; k++; end
      else if (x % 2 == 0) x /= 2;
      else if (y % 2 == 0) y /= 2;
      else if (x > y) x -= y;
      else y -= x;
    end
    return n + 1 + k + 1;
  endfunction

  function automatic int sat(input int c, input int i);
    return (i == 2 && c > 7) ? 7 : c;
  endfunction

  task automatic check_one(input int i, input logic [3:0] st, input logic [31:0] g,
                           input logic [31:0] cy, input logic [31:0] ic);
    chk($sformatf("onehot%0d", i), 32'($countones(st)), 32'd1);
    if (st == 4'b1000) begin
      obs[i] = 0;
      chk($sformatf("held_gcd%0d", i), g, 32'(prev_g[i]));
      chk($sformatf("held_cycles%0d", i), cy, 32'(prev_c[i]));
    end else if (st[2] || st[1]) begin
      if (CEN) obs[i]++;
    end else if (st == 4'b0001) begin
      chk($sformatf("gcd%0d", i), g, 32'(exp_g[i]));
      chk($sformatf("cycles%0d", i), cy, 32'(sat(exp_c[i], i)));
      chk($sformatf("obs_cycles%0d", i), 32'(obs[i]), 32'(exp_c[i]));
      chk($sformatf("icount_done%0d", i), ic, 32'd0);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check_one(0, {qi8, qs8, qm8, qd8}, 32'(g8), 32'(cy8), 32'(ic8));
      check_one(1, {qi16, qs16, qm16, qd16}, 32'(g16), 32'(cy16), 32'(ic16));
      check_one(2, {qis, qss, qms, qds}, 32'(gs), 32'(cys), 32'(ics));
    end
  end

  task automatic clear_prev();
    for (int i = 0; i < 3; i++) begin prev_g[i] = 0; prev_c[i] = 0; end
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] y, input int freeze_at);
    int k;
    logic [7:0] fa, fb;
    logic [15:0] fc;
    logic [3:0] fs;
    @(posedge Clk); #1;
    Ain = x;
    Bin = y;
    exp_g[0] = model_gcd(int'(x[7:0]), int'(y[7:0]));
    exp_c[0] = model_cycles(int'(x[7:0]), int'(y[7:0]));
    exp_g[1] = model_gcd(int'(x), int'(y));
    exp_c[1] = model_cycles(int'(x), int'(y));
    exp_g[2] = exp_g[0];
    exp_c[2] = exp_c[0];
    for (int i = 0; i < 3; i++) lat[i] = 0;
    Start = 1'b1;
    k = 0;
    while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && k < 3000) begin
      @(posedge Clk); #1;
      if (k == 0) begin
        chk("load_a", 32'(a8), 32'(x[7:0]));
        chk("load_b", 32'(b8), 32'(y[7:0]));
      end
      Start = 1'b0;
      k++;
      if (lat[0] == 0 && qd8)  lat[0] = k;
      if (lat[1] == 0 && qd16) lat[1] = k;
      if (lat[2] == 0 && qds)  lat[2] = k;
      if (k == freeze_at) begin
        fa = a8; fb = b8; fc = cy8; fs = {qi8, qs8, qm8, qd8};
        CEN = 1'b0;
        repeat (10) begin
          @(posedge Clk); #1;
          chk("freeze_a", 32'(a8), 32'(fa));
          chk("freeze_b", 32'(b8), 32'(fb));
          chk("freeze_cycles", 32'(cy8), 32'(fc));
          chk("freeze_state", 32'({qi8, qs8, qm8, qd8}), 32'(fs));
        end
        CEN = 1'b1;
      end
    end
    if (lat[0] == 0 || lat[1] == 0 || lat[2] == 0) begin
      chk("timeout_done", 32'd0, 32'd1);
      Reset = 1'b1;
      clear_prev();
      @(posedge Clk); #1;
      Reset = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency%0d", i), 32'(lat[i]), 32'(exp_c[i] + 1));
      prev_g[i] = exp_g[i];
      prev_c[i] = sat(exp_c[i], i);
    end
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
  endtask

  task automatic reset_mid(input logic cen_val);
    @(posedge Clk); #1;
    Ain = 16'd36; Bin = 16'd24; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("in_sub_before_reset", 32'(qs8), 32'd1);
    Reset = 1'b1;
    CEN = cen_val;
    clear_prev();
    @(posedge Clk); #1;
    chk("rst_q_I", 32'(qi8), 32'd1);
    chk("rst_a", 32'(a8), 32'd0);
    chk("rst_b", 32'(b8), 32'd0);
    chk("rst_gcd", 32'(g8), 32'd0);
    chk("rst_icount", 32'(ic8), 32'd0);
    chk("rst_cycles", 32'(cy8), 32'd0);
    chk("rst_cycles16", 32'(cy16), 32'd0);
    Reset = 1'b0;
    CEN = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; CEN = 1'b1; Start = 1'b0; Ack = 1'b0; Ain = '0; Bin = '0;
    clear_prev();
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_q_I", 32'({qi8, qs8, qm8, qd8}), 32'h8);
    chk("reset_a", 32'(a8), 32'd0);
    chk("reset_b", 32'(b8), 32'd0);
    chk("reset_gcd", 32'(g8), 32'd0);
    chk("reset_icount", 32'(ic8), 32'd0);
    chk("reset_cycles", 32'(cy8), 32'd0);
    Reset = 1'b0;
    chk_en = 1'b1;

    chk("model_gcd_36_24", 32'(model_gcd(36, 24)), 32'd12);
    chk("model_cyc_36_24", 32'(model_cycles(36, 24)), 32'd9);
    chk("model_gcd_15_5", 32'(model_gcd(15, 5)), 32'd5);
    chk("model_cyc_15_5", 32'(model_cycles(15, 5)), 32'd4);
    chk("model_gcd_0_42", 32'(model_gcd(0, 42)), 32'd42);
    chk("model_cyc_0_42", 32'(model_cycles(0, 42)), 32'd0);
    chk("model_gcd_0_0", 32'(model_gcd(0, 0)), 32'd0);

    run(16'd36, 16'd24, -1);
    chk("ack_back_to_q_I", 32'(qi8), 32'd1);
    chk("ack_gcd_held", 32'(g8), 32'd12);
    chk("ack_cycles_held", 32'(cy8), 32'd9);
    chk("sat_cycles_36_24", 32'(cys), 32'd7);

    run(16'd15, 16'd5, -1);
    chk("gcd_15_5", 32'(g8), 32'd5);
    chk("cycles_15_5", 32'(cy8), 32'd4);

    run(16'd0, 16'd42, -1);
    chk("zero_latency", 32'(lat[0]), 32'd1);
    chk("gcd_0_42", 32'(g8), 32'd42);
    chk("cycles_0_42", 32'(cy8), 32'd0);
    run(16'd0, 16'd0, -1);
    chk("gcd_0_0", 32'(g8), 32'd0);

    run(16'd36, 16'd24, 2);
    chk("freeze_final_gcd", 32'(g8), 32'd12);
    chk("freeze_final_cycles", 32'(cy8), 32'd9);

    reset_mid(1'b1);
    reset_mid(1'b0);

    // Start seen outside q_I must not disturb a run; Ack outside q_Done is ignored.
    @(posedge Clk); #1;
    Ack = 1'b1;
    @(posedge Clk); #1;
    chk("ack_ignored_in_q_I", 32'(qi8), 32'd1);
    Ack = 1'b0;

    for (int x = 2; x <= 63; x++)
      for (int y = 2; y <= 63; y += 3)
        run(16'(x), 16'(y), -1);

    for (int n = 0; n < 100; n++)
      run(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), -1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ee354_gcd_param.md
Name: ee354_gcd_param

Overview:
- Parametrised next-generation GCD core for the ee354 lab designs.
- Computes GCD(Ain, Bin) for WIDTH-bit unsigned operands using subtract/halve reduction, then a doubling (Mult) phase that restores common factors of 2.
- Adds three things: zero-operand short-cut, a registered result held across runs, and a saturating cycle-count output.
- Sits under the lab TOP, which drives CEN for single-stepping and Start/Ack from buttons.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, width of i_count (factor-of-2 counter).
- CYC_W, 16, width of the Cycles counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- CEN  in  1  clock enable; 0 freezes all state.
- Start  in  1  begin computation (sampled in q_I).
- Ack  in  1  acknowledge result (sampled in q_Done).
- Ain  in  WIDTH  operand A.
- Bin  in  WIDTH  operand B.
- A  out  WIDTH  working register A.
- B  out  WIDTH  working register B.
- AB_GCD  out  WIDTH  registered result.
- i_count  out  CNT_W  common-factor-of-2 count.
- Cycles  out  CYC_W  clocks spent in q_Sub plus q_Mult for the last or current run.
- q_I, q_Sub, q_Mult, q_Done  out  1 each  one-hot state outputs.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high and overrides CEN.
- Reset values: state=q_I; A, B, AB_GCD, i_count and Cycles all 0.
- CEN=0: state and every register hold; no data changes at all.
- All transitions and updates below apply only on enabled edges (CEN=1, Reset=0).
- q_I:
  - A<=Ain, B<=Bin, i_count<=0 on every edge.
  - If Start=1 and (Ain==0 or Bin==0): go to q_Done, AB_GCD<=Ain|Bin, Cycles<=0. GCD(0,0)=0.
  - Else if Start=1: go to q_Sub, Cycles<=0.
  - Else stay in q_I.
- q_Sub, one action per edge, in this priority:
  1. A==B: go to q_Mult; A and B unchanged.
  2. A and B both even: A<=A>>1, B<=B>>1, i_count<=i_count+1.
  3. A even: A<=A>>1.
  4. B even: B<=B>>1.
  5. A>B: A<=A-B.
  6. Otherwise: B<=B-A.
- q_Mult:
  - If i_count==0: go to q_Done, AB_GCD<=A.
  - Else: A<=A<<1, i_count<=i_count-1.
  - No overflow is possible, because the result is <= min(Ain, Bin).
- q_Done: when Ack=1, go to q_I. Otherwise stay. AB_GCD stays held in q_I until the next completion.
- Cycles: +1 on each enabled edge while in q_Sub or q_Mult. Saturates at all-ones and never wraps. Stable in q_Done and q_I.
- Start outside q_I and Ack outside q_Done are ignored.
- Reset mid-computation: q_I with all registers zero on the next edge.
- Latency from the Start edge to q_Done is data dependent; it equals Cycles+1 edges.

Decomposition:
- Shared package ee354_gcd_pkg:
  - state encoding localparams (QI=4'b1000, QSUB=4'b0100, QMULT=4'b0010, QDONE=4'b0001), matching the {q_I,q_Sub,q_Mult,q_Done} order;
  - default WIDTH.
- One sub-module, ee354_sat_counter (parameter W; ports clr, inc, en, q). It is instantiated for Cycles.

Test Plan:
- WIDTH=8, Ain=36, Bin=24, Start pulse -> 6 q_Sub and 3 q_Mult cycles; AB_GCD=12, Cycles=9; Ack -> q_I with AB_GCD still 12.
- Ain=15, Bin=5 -> AB_GCD=5, Cycles=4, i_count=0 in q_Done.
- Ain=0, Bin=42 -> q_Done on the edge after Start, AB_GCD=42, Cycles=0. Ain=0, Bin=0 -> AB_GCD=0.
- Ain=36, Bin=24 with CEN held 0 for 10 clocks mid-q_Sub -> A, B, state and Cycles frozen; final result AB_GCD=12, Cycles=9.
- Reset asserted in q_Sub -> next edge q_I=1 and A, B, AB_GCD, i_count, Cycles all 0. Also: CEN=0 with Reset=1 still resets.
- Sweep Ain, Bin over 2..63 (WIDTH=8) and 100 random pairs (WIDTH=16) -> AB_GCD matches the bench model; Cycles equals the clocks counted from the q_Sub entry to the q_Done entry.
